// File: rtl/a2d_seq.sv
// -----------------------------------------------------------------------------
// a2d_seq -- round-robin A2D conversion sequencer over a shared SPI master
//
// A free-running timer starts a conversion round every 2^PERIOD_W clocks. For
// each slot of the round the block issues two 16-bit SPI transactions to the
// A2D. The first selects the channel. The second repeats the same command and
// returns the conversion result, whose low 12 bits are loaded into that slot's
// channel register.
//
// Optional feature (compile-time macro):
//   A2D_CURR_PRIO_EN  slot order becomes curr, batt, curr, brake, curr, torque
//                     (6 slots). Without it the order is batt, curr, brake,
//                     torque (4 slots).
//
// Parameters:
//   PERIOD_W   round-start timer width (round period = 2^PERIOD_W clocks)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   snd        1-cycle pulse: start an SPI transaction
//   cmd[15:0]  SPI command word, valid with snd and held until the next snd
//   done       1-cycle pulse from the SPI master: transaction finished
//   resp[15:0] SPI receive word, valid with done
//   batt, curr, brake, torque [11:0]  latest conversion per channel
//   rnd_vld    1-cycle pulse after the last slot of a round has loaded
//   ovr        1-cycle pulse when a round-start tick hits a busy sequencer
// -----------------------------------------------------------------------------
module a2d_seq #(
    parameter int PERIOD_W = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        snd,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] resp,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] brake,
    output logic [11:0] torque,
    output logic        rnd_vld,
    output logic        ovr
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WAIT1,
        GAP,
        READ,
        WAIT2
    } state_t;

    typedef enum logic [1:0] {
        REG_BATT,
        REG_CURR,
        REG_BRAKE,
        REG_TORQUE
    } reg_sel_t;

`ifdef A2D_CURR_PRIO_EN
    localparam int NUM_SLOTS = 6;
`else
    localparam int NUM_SLOTS = 4;
`endif
    localparam logic [2:0] LAST_SLOT = 3'(NUM_SLOTS - 1);

    // Which channel register a slot feeds.
    function automatic reg_sel_t slot_reg(input logic [2:0] s);
`ifdef A2D_CURR_PRIO_EN
        case (s)
            3'd1:    slot_reg = REG_BATT;
            3'd3:    slot_reg = REG_BRAKE;
            3'd5:    slot_reg = REG_TORQUE;
            default: slot_reg = REG_CURR;   // slots 0, 2, 4
        endcase
`else
        case (s)
            3'd0:    slot_reg = REG_BATT;
            3'd1:    slot_reg = REG_CURR;
            3'd2:    slot_reg = REG_BRAKE;
            default: slot_reg = REG_TORQUE;
        endcase
`endif
    endfunction

    // Physical A2D mux input wired to each logical channel.
    function automatic logic [2:0] reg_chnl(input reg_sel_t r);
        case (r)
            REG_BATT:  reg_chnl = 3'd0;
            REG_CURR:  reg_chnl = 3'd1;
            REG_BRAKE: reg_chnl = 3'd3;
            default:   reg_chnl = 3'd4;
        endcase
    endfunction

    // The A2D's upper response nibble carries no data.
    logic unused_resp;
    assign unused_resp = ^resp[15:12];

    // -------------------------------------------------------------------------
    // Round-start timer
    // -------------------------------------------------------------------------
    logic [PERIOD_W-1:0] timer;
    logic                tick;

    assign tick = &timer;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of its neighbours; blocking here would make results
    // depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else begin
            timer <= timer + PERIOD_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    state_t     state, state_nxt;
    logic [2:0] slot, slot_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            slot  <= '0;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default assignment first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = CMD;
                    slot_nxt  = '0;
                end
            end
            CMD:   state_nxt = WAIT1;
            WAIT1: if (done) state_nxt = GAP;
            GAP:   state_nxt = READ;
            READ:  state_nxt = WAIT2;
            WAIT2: begin
                if (done) begin
                    if (slot == LAST_SLOT) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = CMD;
                        slot_nxt  = slot + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output logic
    // Outputs are computed one cycle early and registered, so snd/cmd appear
    // in the same cycle the FSM is in CMD or READ and are glitch-free.
    // -------------------------------------------------------------------------
    logic        snd_nxt;
    logic [15:0] cmd_nxt;
    logic        rnd_nxt;
    logic        ovr_nxt;
    logic        load;

    always_comb begin
        snd_nxt = (state_nxt == CMD) || (state_nxt == READ);
        cmd_nxt = cmd;
        // READ re-sends the held command; only entry to CMD picks a new one.
        if (state_nxt == CMD) begin
            cmd_nxt = {2'b00, reg_chnl(slot_reg(slot_nxt)), 11'h000};
        end
        load    = (state == WAIT2) && done;
        rnd_nxt = load && (slot == LAST_SLOT);
        // Ticks seen while busy are dropped, not queued. This also covers a
        // tick coinciding with the final done, since the FSM is still in WAIT2.
        ovr_nxt = tick && (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snd     <= 1'b0;
            cmd     <= 16'h0000;
            rnd_vld <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            snd     <= snd_nxt;
            cmd     <= cmd_nxt;
            rnd_vld <= rnd_nxt;
            ovr     <= ovr_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Channel registers: loaded only on their own slot's second done
    // -------------------------------------------------------------------------
    // NOTE: these data registers are reset explicitly. Downstream logic reads
    // them before the first round completes, so they must come up at a known
    // zero rather than X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            batt   <= 12'h000;
            curr   <= 12'h000;
            brake  <= 12'h000;
            torque <= 12'h000;
        end else if (load) begin
            case (slot_reg(slot))
                REG_BATT:  batt   <= resp[11:0];
                REG_CURR:  curr   <= resp[11:0];
                REG_BRAKE: brake  <= resp[11:0];
                default:   torque <= resp[11:0];
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_seq.sv
// -----------------------------------------------------------------------------
// tb_a2d_seq -- self-checking bench for a2d_seq (PERIOD_W = 6)
//
// An SPI responder answers each snd after a programmable latency. A
// transaction-counting model predicts snd/cmd/rnd_vld/ovr and the channel
// registers every cycle. Directed tests cover the nominal round, cmd
// sequence, spurious done, long-latency overrun, reset mid-round and
// (with A2D_CURR_PRIO_EN) the curr-priority order.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_a2d_seq;

    localparam int PW     = 6;
    localparam int PERIOD = 1 << PW;

`ifdef A2D_CURR_PRIO_EN
    localparam int NSLOT = 6;
    localparam int SLOT_REG [6] = '{1, 0, 1, 2, 1, 3};
    localparam logic [15:0] EXP_CMDS [12] = '{
        16'h0800, 16'h0800, 16'h0000, 16'h0000, 16'h0800, 16'h0800,
        16'h1800, 16'h1800, 16'h0800, 16'h0800, 16'h2000, 16'h2000};
`else
    localparam int NSLOT = 4;
    localparam int SLOT_REG [4] = '{0, 1, 2, 3};
    localparam logic [15:0] EXP_CMDS [8] = '{
        16'h0000, 16'h0000, 16'h0800, 16'h0800,
        16'h1800, 16'h1800, 16'h2000, 16'h2000};
`endif
    localparam int REG_CHNL [4] = '{0, 1, 3, 4};

    logic        clk;
    logic        rst_n;
    logic        snd;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] resp;
    logic [11:0] batt, curr, brake, torque;
    logic        rnd_vld;
    logic        ovr;

    logic        spi_done;
    logic [15:0] spi_resp;
    logic        spur_done;

    assign done = spi_done | spur_done;
    assign resp = spur_done ? 16'hFABC : spi_resp;

    a2d_seq #(.PERIOD_W(PW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .snd     (snd),
        .cmd     (cmd),
        .done    (done),
        .resp    (resp),
        .batt    (batt),
        .curr    (curr),
        .brake   (brake),
        .torque  (torque),
        .rnd_vld (rnd_vld),
        .ovr     (ovr)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- clock and cycle counter ----------------
    int cyc = 0;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- test configuration (stimulus process only) ----------------
    int lat      = 1;
    bit spur_gap = 1'b0;
    bit chk_gap  = 1'b0;
    bit inc_mode = 1'b0;

    // ---------------- SPI responder ----------------
    logic [15:0] cmd_log[$];
    initial begin
        logic [15:0] c;
        logic [2:0]  ch;
        bit          odd;
        bit          gap_pending;
        int          done_cyc;
        int          ch1_n;
        odd = 1'b0; gap_pending = 1'b0; done_cyc = 0; ch1_n = 0;
        spi_done = 1'b0;
        spi_resp = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                odd = 1'b0;
                gap_pending = 1'b0;
                ch1_n = 0;
            end else if (snd) begin
                if (chk_gap && gap_pending)
                    check("gap_cycles", cyc - done_cyc, 2);
                gap_pending = 1'b0;
                c  = cmd;
                cmd_log.push_back(c);
                ch = c[13:11];
                odd = !odd;
                repeat (lat) @(posedge clk);
                #1;
                if (ch == 3'd1) ch1_n++;
                spi_done = 1'b1;
                if (inc_mode && ch == 3'd1)
                    spi_resp = 16'hF000 | 16'(ch1_n / 2);
                else
                    spi_resp = 16'hF000 | (16'(ch) * 16'h111);
                done_cyc = cyc;
                @(posedge clk);
                #1;
                if (spur_gap && odd) begin
                    // Stretch done into the GAP cycle with junk data.
                    spi_resp = 16'hFDEF;
                    @(posedge clk);
                    #1;
                end
                spi_done = 1'b0;
                gap_pending = odd;
            end
        end
    end

    // ---------------- output event counters ----------------
    int snd_cnt = 0, rnd_cnt = 0, ovr_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (snd)     snd_cnt++;
            if (rnd_vld) rnd_cnt++;
            if (ovr)     ovr_cnt++;
        end
    end

    // ---------------- behavioural model ----------------
    // Tracks a round as a count of SPI transactions: odd ones select the
    // channel, even ones deliver data for slot (n-1)/2.
    bit          exp_snd, exp_rnd, exp_ovr;
    logic [15:0] exp_cmd;
    logic [11:0] exp_reg [4];
    int          m_t, m_slot, m_nsnd;
    bit          m_in_round, m_outstanding, m_gap;

    function automatic logic [15:0] cmd_of(input int s);
        logic [2:0] ch;
        ch = 3'(REG_CHNL[SLOT_REG[s]]);
        return {2'b00, ch, 11'h000};
    endfunction

    task automatic model_reset();
        exp_snd = 1'b0; exp_rnd = 1'b0; exp_ovr = 1'b0; exp_cmd = 16'h0000;
        for (int i = 0; i < 4; i++) exp_reg[i] = 12'h000;
        m_t = 0; m_slot = 0; m_nsnd = 0;
        m_in_round = 1'b0; m_outstanding = 1'b0; m_gap = 1'b0;
    endtask

    task automatic model_step();
        bit tick, snd_was;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tick    = (m_t == PERIOD - 1);
        m_t     = (m_t + 1) % PERIOD;
        snd_was = exp_snd;
        exp_snd = 1'b0;
        exp_rnd = 1'b0;
        exp_ovr = tick && m_in_round;
        if (!m_in_round) begin
            if (tick) begin
                m_in_round = 1'b1;
                m_slot  = 0;
                m_nsnd  = 1;
                exp_snd = 1'b1;
                exp_cmd = cmd_of(0);
            end
        end else if (snd_was) begin
            m_outstanding = 1'b1;
        end else if (m_gap) begin
            m_gap   = 1'b0;
            m_nsnd++;
            exp_snd = 1'b1;
        end else if (m_outstanding && done) begin
            m_outstanding = 1'b0;
            if (m_nsnd % 2 == 1) begin
                m_gap = 1'b1;
            end else begin
                exp_reg[SLOT_REG[m_slot]] = resp[11:0];
                if (m_slot == NSLOT - 1) begin
                    m_in_round = 1'b0;
                    exp_rnd = 1'b1;
                end else begin
                    m_slot++;
                    m_nsnd++;
                    exp_snd = 1'b1;
                    exp_cmd = cmd_of(m_slot);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("snd", snd, exp_snd);
            check("rnd_vld", rnd_vld, exp_rnd);
            check("ovr", ovr, exp_ovr);
            check("batt", batt, exp_reg[0]);
            check("curr", curr, exp_reg[1]);
            check("brake", brake, exp_reg[2]);
            check("torque", torque, exp_reg[3]);
            if (exp_snd) check("cmd", cmd, exp_cmd);
        end
    end

    // ---------------- stimulus helpers ----------------
    int rel_cyc;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (100) @(negedge clk);
        check("rst_snd", snd, 0);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_rnd", rnd_vld, 0);
        check("rst_ovr", ovr, 0);
        check("rst_regs", {batt, curr, brake, torque}, 0);
        check("rst_torque", torque, 12'h000);
        rst_n = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic wait_snd(input int count, input int max, input string name);
        int n = 0, seen = 0;
        while (n < max && seen < count) begin
            @(negedge clk);
            if (snd) seen++;
            n++;
        end
        check(name, seen, count);
    endtask

    task automatic wait_rnd(input int max, input string name);
        int  n = 0;
        bit  hit = 1'b0;
        while (n < max && !hit) begin
            @(negedge clk);
            if (rnd_vld) hit = 1'b1;
            n++;
        end
        check(name, hit, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_nominal_regs(input string tag);
        check({tag, "_batt"},   batt,   12'h000);
        check({tag, "_curr"},   curr,   12'h111);
        check({tag, "_brake"},  brake,  12'h333);
        check({tag, "_torque"}, torque, 12'h444);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int s0, r0, o0, l0;
        rst_n = 1'b0;
        spur_done = 1'b0;

        // Test 1: nominal round, min latency, spurious done in IDLE and GAP.
        lat = 1; spur_gap = 1'b1; chk_gap = 1'b1;
        do_reset();
        s0 = snd_cnt; r0 = rnd_cnt; l0 = cmd_log.size();
        repeat (10) @(posedge clk);
        #1 spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
        check("idle_spur_regs", {batt, curr, brake, torque}, 0);
        wait_snd(1, 200, "first_snd_seen");
        check("first_snd_delay", cyc - rel_cyc, PERIOD);
        wait_rnd(400, "round1_done");
        check_nominal_regs("round1");
        check("round1_rnd_cnt", rnd_cnt - r0, 1);
        check("round1_snd_cnt", snd_cnt - s0, 2 * NSLOT);
        for (int i = 0; i < 2 * NSLOT; i++)
            check($sformatf("cmd_seq%0d", i), cmd_log[l0 + i], EXP_CMDS[i]);
        spur_gap = 1'b0; chk_gap = 1'b0;

        // Test 2: done delayed 80 cycles -> ovr on every wrap, round intact.
        lat = 80;
        do_reset();
        r0 = rnd_cnt; o0 = ovr_cnt;
        wait_rnd(2000, "slow_round_done");
        check_nominal_regs("slow");
        check("slow_rnd_cnt", rnd_cnt - r0, 1);
        check("slow_ovr_enough", (ovr_cnt - o0) >= 9, 1);

        // Test 3: reset during WAIT2 of the brake slot, then a clean round.
        lat = 10;
        do_reset();
        wait_snd(2 * 3, 400, "reach_brake_wait2");
        repeat (3) @(negedge clk);
        check("pre_abort_brake", brake, 12'h000);
        do_reset();
        wait_rnd(400, "post_abort_round");
        check_nominal_regs("post_abort");

`ifdef A2D_CURR_PRIO_EN
        // Test 4: curr priority order, curr responses 1,2,3.
        lat = 1; inc_mode = 1'b1;
        do_reset();
        s0 = snd_cnt;
        wait_rnd(400, "prio_round");
        check("prio_curr", curr, 12'h003);
        check("prio_snd_cnt", snd_cnt - s0, 12);
        inc_mode = 1'b0;
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
